// File: rtl/impl_window_checker_if.sv
// impl_window_checker_if: bundles the enable, the per-channel antecedent/consequent
// inputs and the result outputs of impl_window_checker.
// The master modport drives stimulus and observes results; the slave modport is the checker.
// When IMPL_CHK_COVER_EN is defined, the bundle also carries cover_cnt and cover_seen.
interface impl_window_checker_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
);
    logic             en;
    logic [NCH-1:0]   ante;
    logic [NCH-1:0]   cons;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   pass;
    logic [NCH-1:0]   fail;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] drop_cnt;
`ifdef IMPL_CHK_COVER_EN
    logic [CNT_W-1:0] cover_cnt;
    logic [NCH-1:0]   cover_seen;

    modport master (
        output en, ante, cons,
        input  busy, pass, fail, fail_cnt, drop_cnt, cover_cnt, cover_seen
    );

    modport slave (
        input  en, ante, cons,
        output busy, pass, fail, fail_cnt, drop_cnt, cover_cnt, cover_seen
    );
`else
    modport master (
        output en, ante, cons,
        input  busy, pass, fail, fail_cnt, drop_cnt
    );

    modport slave (
        input  en, ante, cons,
        output busy, pass, fail, fail_cnt, drop_cnt
    );
`endif
endinterface

// File: rtl/impl_window_checker.sv
// impl_window_checker: NCH-channel hardware monitor for "ante |-> ##[MIN_DLY:MAX_DLY] cons".
// Every evaluated attempt ends in exactly one pass or fail pulse, one cycle after the
// deciding sample. Fails and busy-channel antecedent drops are counted with saturation.
// Optional feature macro: IMPL_CHK_COVER_EN adds cover_cnt (saturating count of pass pulses)
// and cover_seen (sticky per-channel "has passed at least once").
module impl_window_checker #(
    parameter int NCH     = 4,
    parameter int MIN_DLY = 0,
    parameter int MAX_DLY = 5,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    impl_window_checker_if.slave bus
);
    // Offset counter only has to reach MAX_DLY; keep at least one bit for the MAX_DLY=0 case.
    localparam int OW = (MAX_DLY > 0) ? $clog2(MAX_DLY + 1) : 1;
    // Width wide enough to hold a popcount of NCH bits.
    localparam int PW = $clog2(NCH + 1);
    localparam logic [OW-1:0] MAX_K = OW'(MAX_DLY);

    // Reject parameter combinations that describe an empty window or no channels.
    generate
        if (MAX_DLY < MIN_DLY || MIN_DLY < 0 || NCH < 1) begin : g_bad_params
            $error("impl_window_checker: requires NCH >= 1 and 0 <= MIN_DLY <= MAX_DLY");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t         state      [NCH];
    state_t         state_next [NCH];
    logic [OW-1:0]  offset     [NCH];
    logic [OW-1:0]  off_next   [NCH];

    logic [NCH-1:0] min_ok;
    logic [NCH-1:0] pass_next;
    logic [NCH-1:0] fail_next;
    logic [NCH-1:0] drop_next;
    logic [NCH-1:0] pass_q;
    logic [NCH-1:0] fail_q;
    logic [NCH-1:0] busy_w;
    logic [CNT_W-1:0] fail_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;

    function automatic logic [PW-1:0] popcount(input logic [NCH-1:0] v);
        logic [PW-1:0] pc;
        pc = '0;
        for (int i = 0; i < NCH; i++) begin
            pc = pc + PW'(v[i]);
        end
        return pc;
    endfunction

    // Adds a small increment and clamps at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [PW-1:0] n);
        logic [CNT_W+PW-1:0] s;
        s = {{PW{1'b0}}, c} + {{CNT_W{1'b0}}, n};
        if (s[CNT_W+PW-1:CNT_W] != '0) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    // With MIN_DLY=0 the consequent counts at any offset, so no comparator is built.
    generate
        for (genvar g = 0; g < NCH; g++) begin : g_min_ok
            if (MIN_DLY == 0) begin : g_any
                assign min_ok[g] = 1'b1;
            end else begin : g_cmp
                localparam logic [OW-1:0] MIN_K = OW'(MIN_DLY);
                assign min_ok[g] = (offset[g] >= MIN_K);
            end
        end
    endgenerate

    // Per-channel next state, offset, result pulses and drop detection.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_next[i] = state[i];
            off_next[i]   = offset[i];
            pass_next[i]  = 1'b0;
            fail_next[i]  = 1'b0;
            drop_next[i]  = 1'b0;
            if (!bus.en) begin
                state_next[i] = ST_IDLE;
                off_next[i]   = '0;
            end else begin
                case (state[i])
                    ST_IDLE: begin
                        if (bus.ante[i]) begin
                            if (MIN_DLY == 0 && bus.cons[i]) begin
                                pass_next[i] = 1'b1;
                            end else if (MAX_DLY == 0) begin
                                fail_next[i] = 1'b1;
                            end else begin
                                state_next[i] = ST_WAIT;
                                off_next[i]   = OW'(1);
                            end
                        end
                    end
                    ST_WAIT: begin
                        drop_next[i] = bus.ante[i];
                        if (bus.cons[i] && min_ok[i]) begin
                            pass_next[i]  = 1'b1;
                            state_next[i] = ST_IDLE;
                            off_next[i]   = '0;
                        end else if (offset[i] == MAX_K) begin
                            fail_next[i]  = 1'b1;
                            state_next[i] = ST_IDLE;
                            off_next[i]   = '0;
                        end else begin
                            off_next[i]   = offset[i] + OW'(1);
                        end
                    end
                    default: begin
                        state_next[i] = ST_IDLE;
                        off_next[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Channel state, offsets, registered pulses and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state[i]  <= ST_IDLE;
                offset[i] <= '0;
            end
            pass_q     <= '0;
            fail_q     <= '0;
            fail_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state[i]  <= state_next[i];
                offset[i] <= off_next[i];
            end
            pass_q     <= pass_next;
            fail_q     <= fail_next;
            fail_cnt_q <= sat_add(fail_cnt_q, popcount(fail_next));
            drop_cnt_q <= sat_add(drop_cnt_q, popcount(drop_next));
        end
    end

    // A channel is busy exactly while its registered state holds an open attempt.
    always_comb begin
        busy_w = '0;
        for (int i = 0; i < NCH; i++) begin
            busy_w[i] = (state[i] == ST_WAIT);
        end
    end

    assign bus.busy     = busy_w;
    assign bus.pass     = pass_q;
    assign bus.fail     = fail_q;
    assign bus.fail_cnt = fail_cnt_q;
    assign bus.drop_cnt = drop_cnt_q;

`ifdef IMPL_CHK_COVER_EN
    logic [CNT_W-1:0] cover_cnt_q;
    logic [NCH-1:0]   cover_seen_q;

    // Pass coverage: saturating pass total and sticky first-pass flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cover_cnt_q  <= '0;
            cover_seen_q <= '0;
        end else begin
            cover_cnt_q  <= sat_add(cover_cnt_q, popcount(pass_next));
            cover_seen_q <= cover_seen_q | pass_next;
        end
    end

    assign bus.cover_cnt  = cover_cnt_q;
    assign bus.cover_seen = cover_seen_q;
`endif

endmodule

// File: doc/impl_window_checker.md
Name: impl_window_checker

Overview:
- Synthesizable multi-channel monitor that evaluates implications of the form "ante |-> ##[MIN_DLY:MAX_DLY] cons" in hardware. Each channel reports a pass or fail pulse per evaluated attempt.
- Used as the lowered-hardware reference for implication checks: `|->` is MIN_DLY=0; `|=> ##[a:b]` is MIN_DLY=a+1, MAX_DLY=b+1.
- Generalises single-channel fixed-delay implication to NCH channels with a parametric window, drop accounting and an enable.

Parameters:
- NCH, 4, number of independent channels (>=1)
- MIN_DLY, 0, earliest cycle offset after the antecedent at which the consequent satisfies (0 = same cycle)
- MAX_DLY, 5, latest satisfying offset (>= MIN_DLY, >= 0)
- CNT_W, 16, width of the fail and drop counters

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; low forces all channels idle and suppresses pulses
- ante  in  NCH  per-channel antecedent
- cons  in  NCH  per-channel consequent
- busy  out  NCH  channel has an outstanding attempt (registered)
- pass  out  NCH  one-cycle pulse: attempt satisfied
- fail  out  NCH  one-cycle pulse: window expired without consequent
- fail_cnt  out  CNT_W  total fails across all channels, saturating
- drop_cnt  out  CNT_W  antecedents ignored because their channel was busy, saturating

Behaviour:
- Reset: all outputs 0, all channels IDLE, offset counters 0.
- Per-channel FSM states: IDLE and WAIT. The offset counter is clog2(MAX_DLY+1) bits, minimum 1.
- IDLE, ante=1 at cycle t:
  - MIN_DLY=0 and cons=1 at t: pass=1 at t+1, stay IDLE.
  - MAX_DLY=0 and cons=0: fail=1 at t+1, stay IDLE.
  - Otherwise: go to WAIT with offset=1 at t+1, busy=1.
- WAIT at offset k:
  - cons=1 and k>=MIN_DLY: pass next cycle, go IDLE.
  - Else k==MAX_DLY: fail next cycle, go IDLE.
  - Else offset=k+1.
  - cons before MIN_DLY is ignored; the attempt does not fail early.
- Latency: pass/fail assert exactly one cycle after the deciding sample. pass and fail are never both 1 on the same channel.
- Busy drop: ante=1 while in WAIT, including the cycle in which WAIT resolves, is not evaluated and increments drop_cnt. The channel accepts a new antecedent on the first cycle it is IDLE.
- Multiple channels in one cycle:
  - fail_cnt adds popcount(fail_next) in one step, saturating at all-ones.
  - drop_cnt adds the count of dropped antecedents in one step, saturating at all-ones.
- en=0 handling:
  - Next cycle: every channel goes IDLE, offsets clear, pass/fail/busy are 0, counters hold.
  - Antecedents sampled while en=0 are neither evaluated nor dropped.
  - A channel in WAIT when en falls is abandoned silently.
- Reset mid-attempt: immediate return to reset state; no pulse is produced for abandoned attempts.
- Elaboration error if MAX_DLY < MIN_DLY or NCH < 1.

Optional Feature:
- Macro: IMPL_CHK_COVER_EN.
- Defined:
  - Adds output cover_cnt (CNT_W): a saturating total of pass pulses.
  - Adds output cover_seen (NCH): a sticky bit set on a channel's first pass, cleared only by reset.
- Undefined:
  - Neither port exists and no pass-count logic is built.
  - All other behaviour is identical.

Test Plan:
- Overlap: NCH=4, MIN=0, MAX=0. ante[0]=cons[0]=1 at cycle 3 -> pass[0]=1 at cycle 4. ante[1]=1, cons[1]=0 at cycle 3 -> fail[1]=1 at cycle 4, fail_cnt=1.
- Window: MIN=2, MAX=5. ante[2] at cycle 10; cons[2] at 11 (ignored) and at 13 -> busy[2]=1 in cycles 11-13, pass[2]=1 at 14, no fail.
- Expiry: MIN=2, MAX=5. ante[3] at 20, cons never -> fail[3]=1 at 26 only, busy low from 26.
- Drops: MIN=2, MAX=5. ante[0] held high cycles 30-36, cons[0]=0 -> fail at 36, drop_cnt=5 (cycles 31-35), new attempt starts at 36. Simultaneous fails on all 4 channels -> fail_cnt increases by 4 in one cycle. Preload near all-ones -> saturates.
- Enable/reset: attempt pending on channel 1, en=0 for one cycle -> busy clears next cycle with no pass/fail pulse. rst_n pulsed low asynchronously mid-WAIT -> outputs 0 immediately.
- With IMPL_CHK_COVER_EN: 3 passes on channel 0 and 1 on channel 2 -> cover_cnt=4, cover_seen=4'b0101. Without the macro, the build has no cover ports and all other results are unchanged.
